// File: rtl/screen_draw_ctrl_if.sv
// Circle-engine and VGA-adapter signal bundle around the screen draw sequencer.
// The master modport is the sequencer side; the slave modport is the engine/adapter side.
interface screen_draw_ctrl_if;
  localparam int unsigned X_W = 8;
  localparam int unsigned Y_W = 7;
  localparam int unsigned C_W = 3;

  logic           circ_start;
  logic           circ_plot;
  logic [X_W-1:0] circ_x;
  logic [Y_W-1:0] circ_y;
  logic [C_W-1:0] circ_colour;
  logic           circ_done;
  logic [X_W-1:0] vga_x;
  logic [Y_W-1:0] vga_y;
  logic [C_W-1:0] vga_colour;
  logic           vga_plot;

  modport master (
    output circ_start, vga_x, vga_y, vga_colour, vga_plot,
    input  circ_plot, circ_x, circ_y, circ_colour, circ_done
  );

  modport slave (
    input  circ_start, vga_x, vga_y, vga_colour, vga_plot,
    output circ_plot, circ_x, circ_y, circ_colour, circ_done
  );
endinterface

// File: rtl/screen_draw_ctrl.sv
// One drawing pass: raster-clear the 160x120 frame, launch the circle engine, forward its pixels.
// Optional abort input enabled by defining SCREEN_DRAW_CTRL_ABORT_EN.
module screen_draw_ctrl #(
  parameter int unsigned SCREEN_W     = 160,
  parameter int unsigned SCREEN_H     = 120,
  parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
  input  logic                CLOCK_50,
  input  logic                rst_n,
  input  logic                start,
`ifdef SCREEN_DRAW_CTRL_ABORT_EN
  input  logic                abort,
`endif
  output logic                busy,
  output logic                done,
  screen_draw_ctrl_if.master  bus
);
  localparam int unsigned X_W = 8;
  localparam int unsigned Y_W = 7;
  localparam logic [X_W-1:0] LAST_X = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] LAST_Y = Y_W'(SCREEN_H - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    LAUNCH = 3'd2,
    DRAW   = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t         state;
  logic [X_W-1:0] sx;
  logic [Y_W-1:0] sy;
  logic           abort_c;

`ifdef SCREEN_DRAW_CTRL_ABORT_EN
  assign abort_c = abort;
`else
  assign abort_c = 1'b0;
`endif

  // Sequencer with registered outputs; pulses default low every cycle.
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state          <= IDLE;
      sx             <= '0;
      sy             <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      bus.circ_start <= 1'b0;
      bus.vga_x      <= '0;
      bus.vga_y      <= '0;
      bus.vga_colour <= '0;
      bus.vga_plot   <= 1'b0;
    end else begin
      done           <= 1'b0;
      bus.circ_start <= 1'b0;
      bus.vga_plot   <= 1'b0;
      if (abort_c && (state != IDLE)) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state <= CLEAR;
              sx    <= '0;
              sy    <= '0;
              busy  <= 1'b1;
            end else begin
              busy  <= 1'b0;
            end
          end
          CLEAR: begin
            bus.vga_x      <= sx;
            bus.vga_y      <= sy;
            bus.vga_colour <= CLEAR_COLOUR;
            bus.vga_plot   <= 1'b1;
            // Row-major scan; the last pixel of the last row ends the clear.
            if (sx == LAST_X) begin
              sx <= '0;
              if (sy == LAST_Y) begin
                sy    <= '0;
                state <= LAUNCH;
              end else begin
                sy <= sy + Y_W'(1);
              end
            end else begin
              sx <= sx + X_W'(1);
            end
          end
          LAUNCH: begin
            bus.circ_start <= 1'b1;
            state          <= DRAW;
          end
          DRAW: begin
            bus.vga_x      <= bus.circ_x;
            bus.vga_y      <= bus.circ_y;
            bus.vga_colour <= bus.circ_colour;
            bus.vga_plot   <= bus.circ_plot;
            if (bus.circ_done) begin
              state <= FINISH;
            end
          end
          FINISH: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_screen_draw_ctrl.sv
// Randomized bench for screen_draw_ctrl: clear scan, circle forwarding, reset and optional abort.
module tb_screen_draw_ctrl;
  localparam int unsigned W = 160;
  localparam int unsigned H = 120;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic done;
`ifdef SCREEN_DRAW_CTRL_ABORT_EN
  logic abort = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  screen_draw_ctrl_if bus ();

  screen_draw_ctrl dut (
    .CLOCK_50 (clk),
    .rst_n    (rst_n),
    .start    (start),
`ifdef SCREEN_DRAW_CTRL_ABORT_EN
    .abort    (abort),
`endif
    .busy     (busy),
    .done     (done),
    .bus      (bus)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_circ();
    bus.circ_plot   = 1'b0;
    bus.circ_done   = 1'b0;
    bus.circ_x      = '0;
    bus.circ_y      = '0;
    bus.circ_colour = '0;
  endtask

  // Expected k-th clear pixel of the row-major raster.
  task automatic chk_clear(input int k);
    chk("clr_plot", 32'(bus.vga_plot), 32'd1);
    chk("clr_x", 32'(bus.vga_x), 32'(k % W));
    chk("clr_y", 32'(bus.vga_y), 32'(k / W));
    chk("clr_col", 32'(bus.vga_colour), 32'd0);
    chk("clr_busy", 32'(busy), 32'd1);
  endtask

  task automatic run_pass(input bit hold_start, input bit noise, input bit fixed_circ,
                          input bit do_abort);
    int n;
    int dly;
    logic       p;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    start = 1'b1;
    tick();
    chk("pass_busy_on", 32'(busy), 32'd1);
    chk("pass_plot_first", 32'(bus.vga_plot), 32'd0);
    start = hold_start;
    for (int t = 1; t <= int'(W * H); t++) begin
      if (noise) begin
        bus.circ_plot   = 1'($urandom);
        bus.circ_done   = 1'($urandom);
        bus.circ_x      = 8'($urandom_range(0, W - 1));
        bus.circ_y      = 7'($urandom_range(0, H - 1));
        bus.circ_colour = 3'($urandom);
        if (!hold_start) start = 1'($urandom);
      end
      tick();
      chk_clear(t - 1);
      if (t % 40 == 0) begin
        chk("clr_cstart", 32'(bus.circ_start), 32'd0);
        chk("clr_done", 32'(done), 32'd0);
      end
    end
    // launch cycle; circle inputs here must be ignored
    start = hold_start;
    if (!noise) idle_circ();
    tick();
    chk("launch_cstart", 32'(bus.circ_start), 32'd1);
    chk("launch_plot", 32'(bus.vga_plot), 32'd0);
    chk("launch_busy", 32'(busy), 32'd1);
    idle_circ();
    n   = fixed_circ ? 4 : int'($urandom_range(1, 8));
    dly = fixed_circ ? 0 : int'($urandom_range(0, 3));
    for (int d = 0; d < dly; d++) begin
      tick();
      chk("draw_wait_plot", 32'(bus.vga_plot), 32'd0);
      chk("draw_cstart_once", 32'(bus.circ_start), 32'd0);
    end
    for (int i = 0; i < n; i++) begin
      if (fixed_circ) begin
        p = 1'b1; x = (i == n - 1) ? 8'd81 : 8'd80; y = 7'd60; c = 3'b111;
      end else begin
        p = 1'($urandom);
        x = 8'($urandom_range(0, W - 1));
        y = 7'($urandom_range(0, H - 1));
        c = 3'($urandom);
      end
      bus.circ_plot = p; bus.circ_x = x; bus.circ_y = y; bus.circ_colour = c;
      bus.circ_done = (i == n - 1);
`ifdef SCREEN_DRAW_CTRL_ABORT_EN
      abort = do_abort && (i == n - 1);
`endif
      tick();
      if (do_abort && (i == n - 1)) begin
        chk("abort_plot", 32'(bus.vga_plot), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
      end else begin
        chk("fwd_plot", 32'(bus.vga_plot), 32'(p));
        chk("fwd_x", 32'(bus.vga_x), 32'(x));
        chk("fwd_y", 32'(bus.vga_y), 32'(y));
        chk("fwd_col", 32'(bus.vga_colour), 32'(c));
        chk("fwd_busy", 32'(busy), 32'd1);
      end
      chk("fwd_done", 32'(done), 32'd0);
    end
    idle_circ();
`ifdef SCREEN_DRAW_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    tick();
    if (do_abort) begin
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_idle", 32'(busy), 32'd0);
    end else begin
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_plot", 32'(bus.vga_plot), 32'd0);
      chk("done_busy", 32'(busy), 32'd0);
      tick();
      chk("done_once", 32'(done), 32'd0);
      chk("after_busy", 32'(busy), 32'(hold_start));
    end
  endtask

  initial begin
    idle_circ();
    // reset held with start high
    rst_n = 1'b0;
    start = 1'b1;
    tick();
    tick();
    chk("rst_plot", 32'(bus.vga_plot), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cstart", 32'(bus.circ_start), 32'd0);
    chk("rst_xyc", {17'd0, bus.vga_x, bus.vga_y}, 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    run_pass(1'b0, 1'b1, 1'b1, 1'b0);

    // reset in the middle of the clear scan at pixel (10,5)
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 1; t <= 5 * int'(W) + 11; t++) tick();
    chk("mid_x", 32'(bus.vga_x), 32'd10);
    chk("mid_y", 32'(bus.vga_y), 32'd5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_plot", 32'(bus.vga_plot), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);

    // back-to-back: start held high throughout
    run_pass(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("b2b_plot", 32'(bus.vga_plot), 32'd1);
    chk("b2b_xy", {17'd0, bus.vga_x, bus.vga_y}, 32'd0);
    start = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("b2b_rst_busy", 32'(busy), 32'd0);

`ifdef SCREEN_DRAW_CTRL_ABORT_EN
    run_pass(1'b0, 1'b1, 1'b0, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
